// File: rtl/truth_table_sweeper.sv
// Drives a 3-input gate under test through all 8 input vectors, samples its
// output after a programmable settle time and assembles/compares the truth table.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [7:0]  EXPECTED      = 8'hFC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       out_sample,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic       result_valid,
    output logic [7:0] result_table,
    output logic       match
);

    localparam int unsigned    CW       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    r_state;
    logic [2:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_vec;
    logic          r_busy;
    logic          r_done;
    logic          r_valid;
    logic [7:0]    r_table;
    logic          r_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_vec   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_table <= '0;
            r_match <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                // Partial table is deliberately kept for post-mortem inspection.
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_vec   <= '0;
                r_valid <= 1'b0;
                r_match <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_idx   <= '0;
                            r_vec   <= '0;
                            r_cnt   <= CNT_LOAD;
                            r_table <= '0;
                            r_valid <= 1'b0;
                            r_match <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (r_cnt == '0) begin
                            r_state <= S_SAMPLE;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                    S_SAMPLE: begin
                        r_table[3'd7 - r_idx] <= out_sample;
                        if (r_idx == 3'd7) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_vec   <= r_idx + 3'd1;
                            r_cnt   <= CNT_LOAD;
                            r_state <= S_SETTLE;
                        end
                    end
                    default: begin
                        // r_table already holds the last sample written in SAMPLE.
                        r_valid <= 1'b1;
                        r_match <= (r_table == EXPECTED);
                        r_busy  <= 1'b0;
                        r_vec   <= '0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign in1          = r_vec[2];
    assign in2          = r_vec[1];
    assign in3          = r_vec[0];
    assign busy         = r_busy;
    assign done         = r_done;
    assign result_valid = r_valid;
    assign result_table = r_table;
    assign match        = r_match;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: two sweepers (settle 4 and settle 1) driving behavioural gate models.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    int unsigned total = 0;
    int unsigned bad   = 0;

    // DUT A: SETTLE_CYCLES=4, combinational gate model
    logic       start4 = 1'b0, abort4 = 1'b0, out4;
    logic       a_in1, a_in2, a_in3, a_busy, a_done, a_valid, a_match;
    logic [7:0] a_table;
    logic [2:0] kind4 = 3'd0;
    logic [7:0] rtt4  = 8'h00;

    // DUT B: SETTLE_CYCLES=1, gate model with one cycle of output delay
    logic       start1 = 1'b0, abort1 = 1'b0, out1;
    logic       b_in1, b_in2, b_in3, b_busy, b_done, b_valid, b_match;
    logic [7:0] b_table;

    truth_table_sweeper #(.SETTLE_CYCLES(4), .EXPECTED(8'hFC)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .out_sample(out4),
        .in1(a_in1), .in2(a_in2), .in3(a_in3), .busy(a_busy), .done(a_done),
        .result_valid(a_valid), .result_table(a_table), .match(a_match)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(8'hFC)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .out_sample(out1),
        .in1(b_in1), .in2(b_in2), .in3(b_in3), .busy(b_busy), .done(b_done),
        .result_valid(b_valid), .result_table(b_table), .match(b_match)
    );

    // Gate kinds: 0 NAND(a,b), 1 AND(a,b), 2 XOR3, 3 MAJ3, other: arbitrary table
    function automatic logic gate_fn(input logic [2:0] kind, input logic [7:0] rtt,
                                     input logic a, input logic b, input logic c);
        logic [2:0] i;
        i = {a, b, c};
        case (kind)
            3'd0:    return ~(a & b);
            3'd1:    return a & b;
            3'd2:    return a ^ b ^ c;
            3'd3:    return (a & b) | (a & c) | (b & c);
            default: return rtt[3'd7 - i];
        endcase
    endfunction

    function automatic logic [7:0] ref_table(input logic [2:0] kind, input logic [7:0] rtt);
        logic [7:0] t;
        logic [2:0] v;
        t = '0;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            t[7 - i] = gate_fn(kind, rtt, v[2], v[1], v[0]);
        end
        return t;
    endfunction

    always_comb out4 = gate_fn(kind4, rtt4, a_in1, a_in2, a_in3);
    always_ff @(posedge clk) out1 <= gate_fn(3'd0, 8'h00, b_in1, b_in2, b_in3);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Full sweep on DUT A; optionally re-raises start at edge reissue_at (0 = never).
    task automatic sweep4(input string name, input logic [7:0] exp_tab, input int unsigned reissue_at);
        int unsigned done_at, done_cnt, seq_err;
        logic [2:0] want_vec;
        @(negedge clk); start4 = 1'b1;
        @(posedge clk); #1;
        chk({name, "_busy_start"}, 32'(a_busy), 32'd1);
        chk({name, "_clear_start"}, {23'd0, a_valid, a_table}, 32'd0);
        done_at = 0; done_cnt = 0; seq_err = 0;
        for (int unsigned e = 1; e <= 60; e++) begin
            @(negedge clk); start4 = (e == reissue_at);
            @(posedge clk); #1;
            if (a_done) begin
                done_cnt++;
                if (done_at == 0) done_at = e;
            end
            if (e < 40) begin
                want_vec = 3'(e / 5);
                if ({a_in1, a_in2, a_in3} !== want_vec || a_valid !== 1'b0 || a_busy !== 1'b1)
                    seq_err++;
            end
        end
        start4 = 1'b0;
        chk({name, "_done_edge"}, done_at, 32'd40);
        chk({name, "_done_count"}, done_cnt, 32'd1);
        chk({name, "_vector_seq"}, seq_err, 32'd0);
        chk({name, "_table"}, 32'(a_table), 32'(exp_tab));
        chk({name, "_match"}, 32'(a_match), 32'(exp_tab == 8'hFC));
        chk({name, "_idle"}, {28'd0, a_valid, a_busy, a_in1 | a_in2 | a_in3, a_done}, 32'h8);
    endtask

    typedef struct {
        string       name;
        logic [2:0]  kind;
        logic [7:0]  rtt;
        logic [7:0]  exp_tab;
        int unsigned reissue;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int unsigned done_at, done_cnt, seq_err;
        logic [7:0] r;

        vecs[0] = '{"nand", 3'd0, 8'h00, 8'hFC, 0};
        vecs[1] = '{"and",  3'd1, 8'h00, 8'h03, 0};
        vecs[2] = '{"xor3", 3'd2, 8'h00, 8'h69, 0};
        vecs[3] = '{"maj3", 3'd3, 8'h00, 8'h17, 0};
        vecs[4] = '{"nand_reissue", 3'd0, 8'h00, 8'hFC, 10};
        for (int i = 5; i < 8; i++) begin
            r = 8'($urandom);
            vecs[i] = '{$sformatf("rand%0d", i), 3'd4, r, ref_table(3'd4, r), 0};
        end

        // Reset asserted mid-sweep with start held high
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; start4 = 1'b1; start1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("pre_reset_busy", {30'd0, a_busy, b_busy}, 32'h3);
        @(posedge clk); #2 rst_n = 1'b0;
        #1 chk("reset_a", {17'd0, a_in1, a_in2, a_in3, a_busy, a_done, a_valid, a_match, a_table}, 32'd0);
        chk("reset_b", {17'd0, b_in1, b_in2, b_in3, b_busy, b_done, b_valid, b_match, b_table}, 32'd0);
        @(negedge clk); start4 = 1'b0; start1 = 1'b0; rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("post_reset_idle_a", {17'd0, a_in1, a_in2, a_in3, a_busy, a_done, a_valid, a_match, a_table}, 32'd0);
        chk("post_reset_idle_b", {17'd0, b_in1, b_in2, b_in3, b_busy, b_done, b_valid, b_match, b_table}, 32'd0);

        // Table-driven sweeps on the settle-4 instance
        foreach (vecs[i]) begin
            kind4 = vecs[i].kind;
            rtt4  = vecs[i].rtt;
            chk({vecs[i].name, "_model"}, 32'(ref_table(vecs[i].kind, vecs[i].rtt)), 32'(vecs[i].exp_tab));
            sweep4(vecs[i].name, vecs[i].exp_tab, vecs[i].reissue);
        end

        // Abort raised just after edge 15: vectors 0-2 already captured
        kind4 = 3'd0;
        @(negedge clk); start4 = 1'b1;
        @(posedge clk);
        @(negedge clk); start4 = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk); abort4 = 1'b1;
        @(posedge clk); #1;
        chk("abort_state", {28'd0, a_busy, a_in1 | a_in2 | a_in3, a_valid, a_match}, 32'd0);
        chk("abort_partial_table", 32'(a_table), 32'hE0);
        @(negedge clk); abort4 = 1'b0;
        done_cnt = 0;
        for (int e = 0; e < 45; e++) begin
            @(posedge clk); #1;
            if (a_done || a_busy) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 32'd0);
        chk("abort_table_held", 32'(a_table), 32'hE0);

        // Abort wins over a simultaneous start in IDLE, and clears a held result
        sweep4("nand_before_abort", 8'hFC, 0);
        @(negedge clk); start4 = 1'b1; abort4 = 1'b1;
        @(posedge clk); #1;
        chk("abort_start_idle", {29'd0, a_busy, a_valid, a_match}, 32'd0);
        @(negedge clk); start4 = 1'b0; abort4 = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("abort_start_stays_idle", 32'(a_busy), 32'd0);

        // Settle-1 instance with a gate whose output lags its inputs by one cycle
        @(negedge clk); start1 = 1'b1;
        @(posedge clk);
        done_at = 0; done_cnt = 0; seq_err = 0;
        for (int unsigned e = 1; e <= 30; e++) begin
            @(negedge clk); start1 = 1'b0;
            @(posedge clk); #1;
            if (b_done) begin
                done_cnt++;
                if (done_at == 0) done_at = e;
            end
            if (e < 16 && {b_in1, b_in2, b_in3} !== 3'(e / 2)) seq_err++;
        end
        chk("s1_done_edge", done_at, 32'd16);
        chk("s1_done_count", done_cnt, 32'd1);
        chk("s1_vector_seq", seq_err, 32'd0);
        chk("s1_table", 32'(b_table), 32'(ref_table(3'd0, 8'h00)));
        chk("s1_result", {29'd0, b_valid, b_match, b_busy}, 32'h6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
